// File: rtl/ray_pkg.sv
// ray_pkg: shared FSM state type and width helpers for the write-port arbiter.
// No ports; imported by ray_wr_arbiter.
package ray_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    // Index width: at least one bit even for tiny requester counts.
    function automatic int idw(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction
    // Beat counter must be able to hold the value MAX_BURST itself.
    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin pick of the first set request at or after ptr.
// Ports: req (request vector), ptr (start index), idx (selected index), found (any request set).
module rr_select #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    logic [W-1:0] k;
    // Scanning offsets from far to near lets the nearest hit overwrite the others.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = W'((int'(ptr) + i) % N);
            if (req[k]) begin
                idx   = k;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ray_wr_arbiter.sv
// ray_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Ports: wr_clk/reset (async active-high); req_valid/req_data/req_last in, req_ready out per requester;
//        fifo_wr_en/fifo_din out, fifo_full in; grant_id (current grant) and busy (in GRANT) status.
module ray_wr_arbiter
    import ray_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 8,
    localparam int IDW        = idw(NUM_REQ),
    localparam int CW         = cnt_w(MAX_BURST)
) (
    input  logic                                 wr_clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]                   req_last,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 fifo_wr_en,
    output logic [IDW+DATA_WIDTH-1:0]            fifo_din,
    input  logic                                 fifo_full,
    output logic [IDW-1:0]                       grant_id,
    output logic                                 busy
);
    state_t         state, state_n;
    logic [IDW-1:0] rr_ptr, ptr_n, gid_n, sel_idx;
    logic [CW-1:0]  beat_cnt, cnt_n;
    logic           sel_found;

    rr_select #(.N(NUM_REQ), .W(IDW)) u_sel (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .idx   (sel_idx),
        .found (sel_found)
    );

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            grant_id <= gid_n;
            rr_ptr   <= ptr_n;
            beat_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        gid_n      = grant_id;
        ptr_n      = rr_ptr;
        cnt_n      = beat_cnt;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        busy       = 1'b0;
        if (state == IDLE) begin
            // Outputs stay quiet here: the grant is registered first, giving one bubble cycle.
            if (sel_found) begin
                state_n = GRANT;
                gid_n   = sel_idx;
                cnt_n   = '0;
            end
        end else begin
            busy                = 1'b1;
            req_ready[grant_id] = !fifo_full;
            fifo_wr_en          = req_valid[grant_id] && !fifo_full;
            fifo_din            = {grant_id, req_data[grant_id]};
            if (fifo_wr_en) begin
                cnt_n = beat_cnt + 1'b1;
                if (req_last[grant_id] || cnt_n == CW'(MAX_BURST)) begin
                    state_n = IDLE;
                    ptr_n   = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ray_wr_arbiter.sv
// tb_ray_wr_arbiter: scenario tests plus randomized traffic checked against a burst-level model.
module tb_ray_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 8;
    localparam int OW = 1 + 1 + N + 2 + 2 + DW;

    logic                 wr_clk = 1'b0;
    logic                 reset  = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_last  = '0;
    logic [N-1:0][DW-1:0] req_data  = '0;
    logic [N-1:0]         req_ready;
    logic                 fifo_wr_en;
    logic [DW+1:0]        fifo_din;
    logic                 fifo_full = 1'b0;
    logic [1:0]           grant_id;
    logic                 busy;

    always #5 wr_clk = ~wr_clk;

    ray_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wr_clk     (wr_clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    wire [OW-1:0] obs = {busy, fifo_wr_en, req_ready, grant_id, fifo_din};

    int total = 0;
    int bad   = 0;

    // Model: who owns the port (-1 = nobody), where the next search starts, beats written so far.
    int m_owner = -1, m_ptr = 0, m_cnt = 0, m_gid = 0;
    logic [OW-1:0] e_vec;
    logic          e_wr;
    logic [N-1:0]  e_rdy;

    // Sources: beats left in the current burst and a running sequence number per requester.
    int rem[N];
    int seq[N];
    bit hold[N];

    function automatic void eval();
        e_wr  = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
        e_rdy = (m_owner >= 0 && !fifo_full) ? N'(1 << m_owner) : '0;
        e_vec = {m_owner >= 0, e_wr, e_rdy, 2'(m_gid),
                 (m_owner >= 0) ? {2'(m_owner), req_data[m_owner]} : {(DW+2){1'b0}}};
    endfunction

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            req_valid[r] = rem[r] > 0 && !hold[r];
            req_data[r]  = {8'(r), 8'(seq[r])};
            req_last[r]  = rem[r] == 1;
        end
    endtask

    task automatic adv();
        eval();
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_gid   = m_owner;
                    m_cnt   = 0;
                end
        end else if (e_wr) begin
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        for (int r = 0; r < N; r++)
            if (req_valid[r] && e_rdy[r]) begin
                seq[r]++;
                rem[r]--;
            end
        @(posedge wr_clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_gid = 0;
        fifo_full = 1'b0;
        for (int r = 0; r < N; r++) begin
            rem[r] = 0; seq[r] = 0; hold[r] = 0;
        end
        drive();
        @(posedge wr_clk);
        #1;
        reset = 1'b0;
    endtask

    // Leaves the round-robin pointer at 3 by running one single-beat burst from requester 2.
    task automatic prime_ptr3();
        do_reset();
        rem[2] = 1;
        drive();
        repeat (4) adv();
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        req_last  = 4'(($urandom));
        for (int r = 0; r < N; r++) req_data[r] = 16'($urandom);
        for (int c = 0; c < 3; c++) begin
            @(negedge wr_clk);
            if (obs !== '0) begin
                bad++;
                $display("FAIL reset_hold c=%0d got=%h exp=0", c, obs);
            end
            total++;
        end
        do_reset();
        @(negedge wr_clk);
        eval();
        if (obs !== e_vec) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", obs, e_vec);
        end
        total++;
        adv();
    endtask

    task automatic test_single();
        int first = -1, nwr = 0;
        do_reset();
        rem[0] = 3;
        drive();
        for (int c = 0; c < 7; c++) begin
            @(negedge wr_clk);
            eval();
            if (obs !== e_vec) begin
                bad++;
                $display("FAIL single_model c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            total++;
            if (fifo_wr_en) begin
                if (first < 0) first = c;
                nwr++;
                if (fifo_din[DW+1:DW] !== 2'd0) begin
                    bad++;
                    $display("FAIL single_id c=%0d got=%0d exp=0", c, fifo_din[DW+1:DW]);
                end
                total++;
            end
            if (c == 3 && busy !== 1'b1) begin
                bad++;
                $display("FAIL single_busy3 got=%b exp=1", busy);
            end
            if (c == 4 && busy !== 1'b0) begin
                bad++;
                $display("FAIL single_busy4 got=%b exp=0", busy);
            end
            if (c == 3 || c == 4) total++;
            adv();
        end
        if (first != 1 || nwr != 3) begin
            bad++;
            $display("FAIL single_count first=%0d writes=%0d exp first=1 writes=3", first, nwr);
        end
        total++;
    endtask

    task automatic test_round_robin();
        int ids[$];
        bit prev = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            for (int r = 0; r < N; r++) if (rem[r] == 0) rem[r] = 1;
            drive();
            @(negedge wr_clk);
            eval();
            if (obs !== e_vec) begin
                bad++;
                $display("FAIL rr_model c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            total++;
            if (fifo_wr_en) begin
                ids.push_back(int'(fifo_din[DW+1:DW]));
                if (prev) begin
                    bad++;
                    $display("FAIL rr_bubble c=%0d got=back-to-back exp=idle-gap", c);
                end
                total++;
            end
            prev = fifo_wr_en;
            adv();
        end
        if (ids.size() < 5) begin
            bad++;
            $display("FAIL rr_count got=%0d exp>=5", ids.size());
        end else
            for (int i = 0; i < 5; i++) begin
                if (ids[i] != i % N) begin
                    bad++;
                    $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, ids[i], i % N);
                end
                total++;
            end
        total++;
    endtask

    task automatic test_max_burst();
        int ids[$];
        do_reset();
        rem[2] = 20;
        rem[3] = 1;
        drive();
        for (int c = 0; c < 14; c++) begin
            @(negedge wr_clk);
            eval();
            if (obs !== e_vec) begin
                bad++;
                $display("FAIL maxb_model c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            total++;
            if (fifo_wr_en) ids.push_back(int'(fifo_din[DW+1:DW]));
            if (c == 9) begin
                if (dut.rr_ptr !== 2'd3 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL maxb_ptr got ptr=%0d busy=%b exp ptr=3 busy=0", dut.rr_ptr, busy);
                end
                total++;
            end
            adv();
        end
        if (ids.size() < 9) begin
            bad++;
            $display("FAIL maxb_count got=%0d exp>=9", ids.size());
        end else
            for (int i = 0; i < 9; i++) begin
                if (ids[i] != ((i < MB) ? 2 : 3)) begin
                    bad++;
                    $display("FAIL maxb_id i=%0d got=%0d exp=%0d", i, ids[i], (i < MB) ? 2 : 3);
                end
                total++;
            end
        total++;
    endtask

    task automatic test_full_stall();
        int seqs[$];
        do_reset();
        rem[1] = 6;
        for (int c = 0; c < 16; c++) begin
            fifo_full = (c >= 3 && c < 8);
            drive();
            @(negedge wr_clk);
            eval();
            if (obs !== e_vec) begin
                bad++;
                $display("FAIL stall_model c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            total++;
            if (fifo_full) begin
                if (fifo_wr_en !== 1'b0 || req_ready !== '0 || dut.beat_cnt !== 4'd2) begin
                    bad++;
                    $display("FAIL stall_hold c=%0d got wr=%b rdy=%b cnt=%0d exp wr=0 rdy=0 cnt=2",
                             c, fifo_wr_en, req_ready, dut.beat_cnt);
                end
                total++;
            end
            if (fifo_wr_en) seqs.push_back(int'(fifo_din[7:0]));
            adv();
        end
        fifo_full = 1'b0;
        if (seqs.size() != 6) begin
            bad++;
            $display("FAIL stall_count got=%0d exp=6", seqs.size());
        end else
            for (int i = 0; i < 6; i++) begin
                if (seqs[i] != i) begin
                    bad++;
                    $display("FAIL stall_data i=%0d got=%0d exp=%0d", i, seqs[i], i);
                end
                total++;
            end
        total++;
    endtask

    task automatic test_reset_mid();
        int nwr = 0, first = -1;
        prime_ptr3();
        rem[1] = 8;
        drive();
        for (int c = 0; c < 20 && nwr < 3; c++) begin
            @(negedge wr_clk);
            eval();
            if (obs !== e_vec) begin
                bad++;
                $display("FAIL rstmid_model c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            total++;
            if (fifo_wr_en) nwr++;
            adv();
        end
        if (nwr != 3) begin
            bad++;
            $display("FAIL rstmid_timeout got=%0d exp=3", nwr);
        end
        total++;
        @(negedge wr_clk);
        if (fifo_wr_en !== 1'b1 || grant_id !== 2'd1) begin
            bad++;
            $display("FAIL rstmid_beat4 got wr=%b id=%0d exp wr=1 id=1", fifo_wr_en, grant_id);
        end
        total++;
        #1 reset = 1'b1;
        #1;
        if (obs !== '0) begin
            bad++;
            $display("FAIL rstmid_async got=%h exp=0", obs);
        end
        total++;
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_gid = 0;
        rem[3] = 1;
        drive();
        @(posedge wr_clk);
        #1 reset = 1'b0;
        drive();
        for (int c = 0; c < 6; c++) begin
            @(negedge wr_clk);
            eval();
            if (obs !== e_vec) begin
                bad++;
                $display("FAIL rstmid_after c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            total++;
            if (fifo_wr_en && first < 0) first = int'(fifo_din[DW+1:DW]);
            adv();
        end
        if (first != 1) begin
            bad++;
            $display("FAIL rstmid_regrant got=%0d exp=1", first);
        end
        total++;
    endtask

    task automatic test_valid_drop();
        int n3 = 0, n0 = 0, holdc = 0;
        bit done3 = 0;
        prime_ptr3();
        rem[3] = 5;
        rem[0] = 2;
        for (int c = 0; c < 20; c++) begin
            hold[3] = (n3 >= 2 && holdc < 3);
            if (hold[3]) holdc++;
            drive();
            @(negedge wr_clk);
            eval();
            if (obs !== e_vec) begin
                bad++;
                $display("FAIL drop_model c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            total++;
            if (hold[3]) begin
                if (grant_id !== 2'd3 || fifo_wr_en !== 1'b0) begin
                    bad++;
                    $display("FAIL drop_hold c=%0d got id=%0d wr=%b exp id=3 wr=0", c, grant_id, fifo_wr_en);
                end
                total++;
            end
            if (fifo_wr_en && fifo_din[DW+1:DW] == 2'd3) begin
                n3++;
                if (req_last[3]) done3 = 1;
            end
            if (fifo_wr_en && fifo_din[DW+1:DW] == 2'd0) begin
                n0++;
                if (!done3) begin
                    bad++;
                    $display("FAIL drop_order c=%0d got=id0-write exp=after-id3-last", c);
                end
                total++;
            end
            adv();
        end
        hold[3] = 0;
        if (n3 != 5 || n0 != 2) begin
            bad++;
            $display("FAIL drop_count got n3=%0d n0=%0d exp n3=5 n0=2", n3, n0);
        end
        total++;
    endtask

    task automatic test_random();
        int wr_per[N];
        do_reset();
        for (int r = 0; r < N; r++) wr_per[r] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int r = 0; r < N; r++) begin
                if (rem[r] == 0 && $urandom_range(0, 3) == 0) rem[r] = $urandom_range(1, 12);
                hold[r] = $urandom_range(0, 4) == 0;
            end
            fifo_full = $urandom_range(0, 3) == 0;
            drive();
            @(negedge wr_clk);
            eval();
            if (obs !== e_vec) begin
                bad++;
                $display("FAIL rand_model c=%0d got=%h exp=%h", c, obs, e_vec);
            end
            total++;
            if (fifo_wr_en) wr_per[fifo_din[DW+1:DW]]++;
            adv();
        end
        for (int r = 0; r < N; r++) begin
            if (wr_per[r] == 0) begin
                bad++;
                $display("FAIL rand_starve r=%0d got=0 writes exp>0", r);
            end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_max_burst();
        test_full_stall();
        test_reset_mid();
        test_valid_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
